// File: rtl/key_scheduler.sv
// Debounces nine key lines, arbitrates them, enforces a minimum note length and drives the tone key code.
// Define DEMO_SONG_EN to add a PLAY state that steps through a built-in eight-note scale.
module key_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned MIN_NOTE_CYCLES = 2500000,
  parameter int unsigned BEAT_CYCLES     = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] keys_raw,
  input  logic       play_demo,
  output logic [7:0] key_code,
  output logic       note_on,
  output logic       note_start
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = (MIN_NOTE_CYCLES > 1) ? $clog2(MIN_NOTE_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE      = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(MIN_NOTE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
  localparam logic [7:0]        CODE_SILENT = 8'd9;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SUSTAIN
`ifdef DEMO_SONG_EN
    , PLAY
`endif
  } state_e;

  logic [8:0]      stable_q, stable_d;
  logic [DB_W-1:0] db_cnt_q [9];
  logic [DB_W-1:0] db_cnt_d [9];

  state_e            state_q;
  logic [7:0]        code_q;
  logic              note_on_q;
  logic              note_start_q;
  logic [HOLD_W-1:0] hold_q;

  logic       pause;
  logic       any_key;
  logic [7:0] win_code;
  logic       load_win;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 9; i++) begin
      db_cnt_d[i] = '0;
      if (keys_raw[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) stable_d[i] = keys_raw[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
      end
    end
  end

  // NOTE: the counter array is reset too, since its start value defines the debounce window.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= '0;
      for (int i = 0; i < 9; i++) db_cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Lowest index wins: scanning downward lets the last hit overwrite higher ones.
  always_comb begin
    win_code = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      if (stable_q[i]) win_code = 8'(i + 1);
    end
  end

  assign pause    = stable_q[8];
  assign any_key  = |stable_q[7:0];
  assign load_win = !pause && any_key &&
                    ((state_q == IDLE) ||
`ifdef DEMO_SONG_EN
                     (state_q == PLAY) ||
`endif
                     ((state_q == SUSTAIN) && (win_code != code_q)));

`ifdef DEMO_SONG_EN
  localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LOAD = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  logic [BEAT_W-1:0] beat_q;
  logic              play_q;
  logic              play_rise;

  assign play_rise = play_demo && !play_q;
`else
  logic unused_demo_cfg;
  assign unused_demo_cfg = play_demo ^ BEAT_CYCLES[0];
`endif

  // NOTE: sequential state uses <= only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      code_q       <= CODE_SILENT;
      note_on_q    <= 1'b0;
      note_start_q <= 1'b0;
      hold_q       <= '0;
`ifdef DEMO_SONG_EN
      beat_q       <= '0;
      play_q       <= 1'b0;
`endif
    end else begin
      note_start_q <= 1'b0;
`ifdef DEMO_SONG_EN
      play_q       <= play_demo;
`endif
      if (pause) begin
        state_q   <= IDLE;
        code_q    <= CODE_SILENT;
        note_on_q <= 1'b0;
      end else if (load_win) begin
        state_q      <= HOLD;
        code_q       <= win_code;
        note_on_q    <= 1'b1;
        note_start_q <= 1'b1;
        hold_q       <= HOLD_LOAD;
      end else begin
        case (state_q)
          IDLE: begin
`ifdef DEMO_SONG_EN
            if (play_rise) begin
              state_q      <= PLAY;
              code_q       <= 8'd1;
              note_on_q    <= 1'b1;
              note_start_q <= 1'b1;
              beat_q       <= BEAT_LOAD;
            end
`endif
          end
          HOLD: begin
            // Leave one edge early so SUSTAIN can swap the code exactly MIN_NOTE_CYCLES after the load.
            if (hold_q <= HOLD_ONE) state_q <= SUSTAIN;
            if (hold_q != '0)       hold_q  <= hold_q - HOLD_ONE;
          end
          SUSTAIN: begin
            if (!any_key) begin
              state_q   <= IDLE;
              code_q    <= CODE_SILENT;
              note_on_q <= 1'b0;
            end
          end
`ifdef DEMO_SONG_EN
          PLAY: begin
            if (beat_q != '0) begin
              beat_q <= beat_q - BEAT_ONE;
            end else if (code_q == 8'd8) begin
              state_q   <= IDLE;
              code_q    <= CODE_SILENT;
              note_on_q <= 1'b0;
            end else begin
              code_q       <= code_q + 8'd1;
              note_start_q <= 1'b1;
              beat_q       <= BEAT_LOAD;
            end
          end
`endif
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign key_code   = code_q;
  assign note_on    = note_on_q;
  assign note_start = note_start_q;

endmodule

// File: tb/tb_key_scheduler.sv
// Self-checking bench for key_scheduler: directed scenarios plus random key traffic against a behavioural model.
module tb_key_scheduler;

  localparam int DB = 4;
  localparam int MN = 8;
  localparam int BT = 6;
`ifdef DEMO_SONG_EN
  localparam bit DEMO = 1'b1;
`else
  localparam bit DEMO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] keys_raw = '0;
  logic       play_demo = 1'b0;
  logic [7:0] key_code;
  logic       note_on;
  logic       note_start;

  always #5 clk = ~clk;

  key_scheduler #(
    .DEBOUNCE_CYCLES(DB),
    .MIN_NOTE_CYCLES(MN),
    .BEAT_CYCLES    (BT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .keys_raw  (keys_raw),
    .play_demo (play_demo),
    .key_code  (key_code),
    .note_on   (note_on),
    .note_start(note_start)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a line's stable value flips once the last DB raw samples all disagree with it.
  typedef enum int {M_IDLE, M_NOTE, M_DEMO} mode_e;

  bit [8:0] hist [DB];
  bit [8:0] m_stab;
  bit [8:0] s_old;
  mode_e    m_mode;
  int       m_code;
  bit       m_on;
  bit       m_start;
  int       m_t0;
  bit       m_play_prev;
  bit       model_ok = 1'b0;
  int       n = 0;
  int       w;
  int       k;
  bit       all_diff;

  always @(posedge clk) begin
    n++;
    if (reset) begin
      for (int j = 0; j < DB; j++) hist[j] = '0;
      m_stab      = '0;
      m_mode      = M_IDLE;
      m_code      = 9;
      m_on        = 1'b0;
      m_start     = 1'b0;
      m_t0        = 0;
      m_play_prev = 1'b0;
      model_ok    = 1'b1;
    end else begin
      s_old = m_stab;
      w = 0;
      for (int i = 7; i >= 0; i--) if (s_old[i]) w = i + 1;
      m_start = 1'b0;
      if (s_old[8]) begin
        m_mode = M_IDLE; m_code = 9; m_on = 1'b0;
      end else if (m_mode == M_NOTE && (n - m_t0) < MN) begin
        // minimum note length still running
      end else if (m_mode == M_NOTE) begin
        if (w == 0) begin
          m_mode = M_IDLE; m_code = 9; m_on = 1'b0;
        end else if (w != m_code) begin
          m_code = w; m_on = 1'b1; m_start = 1'b1; m_t0 = n;
        end
      end else if (w != 0) begin
        m_mode = M_NOTE; m_code = w; m_on = 1'b1; m_start = 1'b1; m_t0 = n;
      end else if (m_mode == M_DEMO) begin
        k = n - m_t0;
        if (k >= 8 * BT) begin
          m_mode = M_IDLE; m_code = 9; m_on = 1'b0;
        end else if (k % BT == 0) begin
          m_code = k / BT + 1; m_start = 1'b1;
        end
      end else if (DEMO && play_demo && !m_play_prev) begin
        m_mode = M_DEMO; m_code = 1; m_on = 1'b1; m_start = 1'b1; m_t0 = n;
      end
      m_play_prev = play_demo;

      for (int j = DB - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = keys_raw;
      for (int i = 0; i < 9; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) if (hist[j][i] == m_stab[i]) all_diff = 1'b0;
        if (all_diff) m_stab[i] = ~m_stab[i];
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("cyc_code",  key_code,   m_code);
      check("cyc_on",    note_on,    m_on);
      check("cyc_start", note_start, m_start);
    end
  end

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  int starts;
  int r;
  int dur;
  logic [8:0] pat;

  initial begin
    tick(2);
    check("rst_code",  key_code,   9);
    check("rst_on",    note_on,    0);
    check("rst_start", note_start, 0);
    reset = 1'b0;

    // Key3 press: code loads on edge DB+1
    keys_raw = 9'h004;
    tick(4);
    check("k3_before", key_code, 9);
    tick(1);
    check("k3_code",  key_code,   3);
    check("k3_on",    note_on,    1);
    check("k3_start", note_start, 1);
    check("model_k3", m_code,     3);
    tick(1);
    check("k3_pulse_width", note_start, 0);
    keys_raw = '0;
    tick(20);

    // Short glitch on Key1
    starts = 0;
    keys_raw = 9'h001;
    for (int c = 0; c < 13; c++) begin
      if (c == 3) keys_raw = '0;
      tick(1);
      starts += int'(note_start);
    end
    check("glitch_starts", starts, 0);
    check("glitch_code", key_code, 9);

    // Key5 then Key2: code 5 holds exactly MN cycles
    keys_raw = 9'h010;
    tick(5);
    check("k5_code",  key_code,   5);
    check("k5_start", note_start, 1);
    tick(2);
    keys_raw = 9'h012;
    tick(5);
    check("k5_held", key_code, 5);
    tick(1);
    check("k2_code",  key_code,   2);
    check("k2_start", note_start, 1);
    keys_raw = '0;
    tick(20);

    // Key6 then Pause during HOLD
    keys_raw = 9'h020;
    tick(5);
    check("k6_code", key_code, 6);
    tick(1);
    keys_raw = 9'h120;
    tick(4);
    check("pause_before", key_code, 6);
    tick(1);
    check("pause_code", key_code, 9);
    check("pause_on",   note_on,  0);
    check("model_pause", m_on,    0);
    tick(12);
    check("pause_held_code", key_code, 9);
    keys_raw = 9'h020;
    tick(5);
    check("k6_resume", key_code,   6);
    check("k6_restart", note_start, 1);
    keys_raw = '0;
    tick(20);

    // Key8 then one-cycle reset
    keys_raw = 9'h080;
    tick(5);
    check("k8_code", key_code, 8);
    tick(2);
    reset = 1'b1;
    tick(1);
    check("k8_rst_code",  key_code,   9);
    check("k8_rst_on",    note_on,    0);
    check("k8_rst_start", note_start, 0);
    reset = 1'b0;
    keys_raw = '0;
    tick(10);

`ifdef DEMO_SONG_EN
    // Full demo scale
    play_demo = 1'b1;
    tick(1);
    play_demo = 1'b0;
    check("demo_first", key_code, 1);
    starts = int'(note_start);
    for (int c = 1; c < 8 * BT; c++) begin
      tick(1);
      starts += int'(note_start);
      if (c % BT == 0) check("demo_step", key_code, c / BT + 1);
    end
    tick(1);
    check("demo_end_code", key_code, 9);
    check("demo_end_on",   note_on,  0);
    check("demo_starts",   starts,   8);
    tick(5);

    // Demo aborted by Key4 during code 3
    play_demo = 1'b1;
    tick(1);
    play_demo = 1'b0;
    tick(2 * BT);
    check("abort_pre", key_code, 3);
    keys_raw = 9'h008;
    tick(4);
    check("abort_hold3", key_code, 3);
    tick(1);
    check("abort_code",  key_code,   4);
    check("abort_start", note_start, 1);
    keys_raw = '0;
    tick(20);
`endif

    // Random key traffic
    for (int s = 0; s < 400; s++) begin
      r = $urandom_range(0, 9);
      pat = keys_raw;
      case (r)
        0, 1, 2: pat = '0;
        3, 4, 5: pat = 9'(1 << $urandom_range(0, 7));
        6:       pat = 9'((1 << $urandom_range(0, 7)) | (1 << $urandom_range(0, 7)));
        7:       pat = 9'h100 | 9'($urandom_range(0, 255));
        8:       pat = 9'($urandom_range(0, 511));
        default: ;
      endcase
      keys_raw  = pat;
      play_demo = ($urandom_range(0, 7) == 0);
      dur = $urandom_range(1, 12);
      if ($urandom_range(0, 60) == 0) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
      tick(dur);
    end

    keys_raw  = '0;
    play_demo = 1'b0;
    tick(30);
    check("final_idle", key_code, 9);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
